fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of instruction_mem and drives its 64-bit address input.
- Holds the program counter and issues sequential addresses to the memory.
- Captures each returned 32-bit instruction into a 2-entry output buffer and presents it to decode with a valid/ready handshake.
- Accepts branch redirects that flush every instruction already fetched.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives instruction_mem, and buffers
// returned instructions in a 2-entry FIFO toward decode with branch-redirect flush.

module fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instruction,
    output logic [ADDR_W-1:0]  if_pc
);

    logic [ADDR_W-1:0]  pc_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic [ADDR_W-1:0]  fifo_pc_r    [2];
    logic [INSTR_W-1:0] fifo_instr_r [2];
    logic               rd_ptr_r;
    logic [1:0]         count_r;

    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic [2:0]         occ_s;
    logic               wr_idx_s;
    logic [1:0]         count_nxt_s;

    // Handshake, issue throttle and FIFO write slot.
    always_comb begin
        pop_s    = (count_r != 2'd0) && if_ready;
        push_s   = inflight_r && !branch_valid;
        // Occupancy after this cycle's pop; never let buffered plus in-flight exceed 2.
        occ_s    = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s  = !branch_valid && (occ_s <= 3'd1);
        wr_idx_s = rd_ptr_r ^ count_r[0];
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // PC, in-flight tracking and buffer occupancy; a branch overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else if (branch_valid) begin
            pc_r       <= branch_target;
            inflight_r <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            if (issue_s) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= pc_r;
                pc_r          <= pc_r + ADDR_W'(PC_STEP);
            end else begin
                inflight_r <= 1'b0;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Buffer storage; a full buffer popped and pushed together reuses the head slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
                fifo_instr_r[i] <= {INSTR_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_pc_r[wr_idx_s]    <= inflight_pc_r;
            fifo_instr_r[wr_idx_s] <= imem_instruction;
        end
    end

    // Head is masked when empty so flushed entries never leak onto the outputs.
    always_comb begin
        imem_address = pc_r;
        if_valid     = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            if_instruction = fifo_instr_r[rd_ptr_r];
            if_pc          = fifo_pc_r[rd_ptr_r];
        end else begin
            if_instruction = {INSTR_W{1'b0}};
            if_pc          = {ADDR_W{1'b0}};
        end
    end

    fetch_unit_checker u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .count        (count_r),
        .push         (push_s),
        .pop          (pop_s),
        .issue        (issue_s),
        .inflight     (inflight_r),
        .branch_valid (branch_valid)
    );

endmodule

// Simulation-time invariants of the fetch buffer.
module fetch_unit_checker (
    input logic       clk,
    input logic       reset_n,
    input logic [1:0] count,
    input logic       push,
    input logic       pop,
    input logic       issue,
    input logic       inflight,
    input logic       branch_valid
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !((count == 2'd2) && push && !pop));

    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
        count != 2'd3);

    a_branch_blocks_issue: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue && branch_valid));

    a_occupancy: assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, count} + {2'b00, inflight}) <= 3'd2);

endmodule
